// File: rtl/ucca_violation_ctrl_if.sv
// openMSP430 peripheral bus slice used by the UCCA violation controller.
// The master drives address/data/enables; the slave returns read data.
interface ucca_violation_ctrl_if;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;

   modport master (output per_addr, output per_din, output per_en, output per_we,
                   input  per_dout);
   modport slave  (input  per_addr, input  per_din, input  per_en, input  per_we,
                   output per_dout);
endinterface

// File: rtl/ucca_violation_ctrl.sv
// Turns UCCA monitor violations into a minimum-length PUC request and keeps a
// first-fault log (cause, PC, saturating count) readable over the peripheral bus.
module ucca_violation_ctrl #(
   parameter int unsigned HOLD_CYCLES = 16,
   parameter logic [14:0] BASE_ADDR   = 15'h0190
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  hw_reset,
   input  logic                  integrity_reset,
   input  logic                  return_reset,
   input  logic                  stack_reset,
   input  logic [15:0]           pc,
   ucca_violation_ctrl_if.slave  per,
   output logic                  puc_req,
   output logic                  viol_active
);

   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned CAUSE_W = 4;
   localparam logic [13:0]       BASE_WADDR = BASE_ADDR[14:1];
   localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

   typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

   state_t               state;
   logic [HOLD_W-1:0]    hold_cnt;
   logic                 status_valid;
   logic [CAUSE_W-1:0]   status_cause;
   logic [15:0]          vpc;
   logic [CNT_W-1:0]     count;

   logic                 viol_event;
   logic                 bus_wr;
   logic                 bus_rd;
   logic                 sel_status;
   logic                 sel_vpc;
   logic                 sel_count;
   logic                 status_w1c;
   logic                 count_clr;
   logic [CAUSE_W-1:0]   cause_new;
   logic                 unused_din;

   assign viol_event = hw_reset && (state == IDLE);
   assign bus_wr     = per.per_en && (per.per_we != 2'b00);
   assign bus_rd     = per.per_en && (per.per_we == 2'b00);
   assign sel_status = (per.per_addr == BASE_WADDR);
   assign sel_vpc    = (per.per_addr == BASE_WADDR + 14'd1);
   assign sel_count  = (per.per_addr == BASE_WADDR + 14'd2);
   assign status_w1c = bus_wr && sel_status && per.per_we[1] && per.per_din[15];
   assign count_clr  = bus_wr && sel_count;
   assign cause_new  = {hw_reset & ~(integrity_reset | return_reset | stack_reset),
                        stack_reset, return_reset, integrity_reset};
   assign unused_din = ^per.per_din[14:0];

   // Violation FSM; outputs are registered copies of (state != IDLE)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         puc_req     <= 1'b0;
         viol_active <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hw_reset) begin
                  state       <= HOLD;
                  hold_cnt    <= HOLD_LOAD;
                  puc_req     <= 1'b1;
                  viol_active <= 1'b1;
               end
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  if (hw_reset) begin
                     state <= WAIT;
                  end else begin
                     state       <= IDLE;
                     puc_req     <= 1'b0;
                     viol_active <= 1'b0;
                  end
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            WAIT: begin
               if (!hw_reset) begin
                  state       <= IDLE;
                  puc_req     <= 1'b0;
                  viol_active <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               puc_req     <= 1'b0;
               viol_active <= 1'b0;
            end
         endcase
      end
   end

   // First-fault log; a capture on the same edge as a bus clear takes priority
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         status_valid <= 1'b0;
         status_cause <= '0;
         vpc          <= '0;
         count        <= '0;
      end else if (viol_event) begin
         if (count != CNT_MAX) begin
            count <= count + CNT_W'(1);
         end
         if (!status_valid || status_w1c) begin
            status_valid <= 1'b1;
            status_cause <= cause_new;
            vpc          <= pc;
         end
      end else begin
         if (count_clr) begin
            count <= '0;
         end
         if (status_w1c) begin
            status_valid <= 1'b0;
            status_cause <= '0;
         end
      end
   end

   always_comb begin
      per.per_dout = 16'h0000;
      if (bus_rd) begin
         if (sel_status) begin
            per.per_dout = {status_valid, 11'h000, status_cause};
         end else if (sel_vpc) begin
            per.per_dout = vpc;
         end else if (sel_count) begin
            per.per_dout = {8'h00, count};
         end
      end
   end

endmodule

// File: tb/tb_ucca_violation_ctrl.sv
// Randomised bench for ucca_violation_ctrl against a cycle-count reference model,
// plus directed scenarios with hand-computed expectations.
module tb_ucca_violation_ctrl;

   localparam int unsigned H = 16;
   localparam logic [13:0] A_STATUS = 14'h00C8;
   localparam logic [13:0] A_VPC    = 14'h00C9;
   localparam logic [13:0] A_COUNT  = 14'h00CA;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hw_reset = 1'b0;
   logic        integrity_reset = 1'b0;
   logic        return_reset = 1'b0;
   logic        stack_reset = 1'b0;
   logic [15:0] pc = 16'h0000;
   logic        puc_req;
   logic        viol_active;

   ucca_violation_ctrl_if bus ();

   ucca_violation_ctrl #(.HOLD_CYCLES(H), .BASE_ADDR(15'h0190)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .hw_reset        (hw_reset),
      .integrity_reset (integrity_reset),
      .return_reset    (return_reset),
      .stack_reset     (stack_reset),
      .pc              (pc),
      .per             (bus.slave),
      .puc_req         (puc_req),
      .viol_active     (viol_active)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model: busy for at least H cycles after an event, then until hw_reset drops
   bit          m_busy;
   int unsigned m_elapsed;
   bit          m_valid;
   logic [3:0]  m_cause;
   logic [15:0] m_vpc;
   int          m_count;
   bit          t_ev, t_wr, t_w1c, t_clr;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy = 0; m_elapsed = 0; m_valid = 0; m_cause = 4'h0; m_vpc = 16'h0; m_count = 0;
      end else begin
         t_ev  = hw_reset && !m_busy;
         t_wr  = bus.per_en && (bus.per_we != 2'b00);
         t_w1c = t_wr && (bus.per_addr == A_STATUS) && bus.per_we[1] && bus.per_din[15];
         t_clr = t_wr && (bus.per_addr == A_COUNT);
         if (m_busy) begin
            m_elapsed++;
            if (m_elapsed >= H && !hw_reset) m_busy = 0;
         end else if (t_ev) begin
            m_busy = 1; m_elapsed = 0;
         end
         if (t_ev) begin
            m_count = (m_count < 255) ? m_count + 1 : 255;
            if (!m_valid || t_w1c) begin
               m_valid = 1;
               m_cause = {!(integrity_reset || return_reset || stack_reset),
                          stack_reset, return_reset, integrity_reset};
               m_vpc   = pc;
            end
         end else begin
            if (t_clr) m_count = 0;
            if (t_w1c) begin m_valid = 0; m_cause = 4'h0; end
         end
      end
   end

   function automatic logic [15:0] exp_dout();
      if (!bus.per_en || bus.per_we != 2'b00) return 16'h0000;
      case (bus.per_addr)
         A_STATUS: return {m_valid, 11'h000, m_cause};
         A_VPC:    return m_vpc;
         A_COUNT:  return 16'(m_count);
         default:  return 16'h0000;
      endcase
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_puc_req", 16'(puc_req), 16'(m_busy));
         check("model_viol_active", 16'(viol_active), 16'(m_busy));
         check("model_per_dout", bus.per_dout, exp_dout());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.per_en = 1'b0; bus.per_we = 2'b00; bus.per_addr = 14'h0; bus.per_din = 16'h0;
   endtask

   task automatic rd(input logic [13:0] a, input logic [15:0] exp, input string nm);
      bus.per_addr = a; bus.per_we = 2'b00; bus.per_en = 1'b1;
      #1;
      check(nm, bus.per_dout, exp);
      bus_idle();
   endtask

   task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
      bus.per_addr = a; bus.per_din = d; bus.per_we = we; bus.per_en = 1'b1;
      tick();
      bus_idle();
   endtask

   task automatic set_viol(input logic hw, input logic [2:0] sri, input logic [15:0] p);
      hw_reset = hw; stack_reset = sri[2]; return_reset = sri[1]; integrity_reset = sri[0]; pc = p;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #3;
      reset_n = 1'b1;
      tick();
   endtask

   int n_high;

   initial begin
      bus_idle();
      #2;
      chk_en = 1'b1;
      tick();
      check("reset_puc_req", 16'(puc_req), 16'h0);
      check("reset_viol_active", 16'(viol_active), 16'h0);
      reset_n = 1'b1;
      tick();
      rd(A_STATUS, 16'h0000, "reset_status");

      // 1: single-cycle return violation
      set_viol(1'b1, 3'b010, 16'hE0A4);
      tick();
      set_viol(1'b0, 3'b000, 16'h0000);
      n_high = 0;
      for (int i = 0; i < 40; i++) begin
         if (puc_req) n_high++;
         tick();
      end
      check("t1_puc_high_cycles", 16'(n_high), 16'd16);
      rd(A_STATUS, 16'h8002, "t1_status");
      rd(A_VPC,    16'hE0A4, "t1_vpc");
      rd(A_COUNT,  16'h0001, "t1_count");

      // 2: long stack violation keeps puc_req until hw_reset drops
      do_reset();
      set_viol(1'b1, 3'b100, 16'h1234);
      repeat (40) tick();
      set_viol(1'b0, 3'b000, 16'h0000);
      check("t2_puc_still_high", 16'(puc_req), 16'h1);
      tick();
      check("t2_puc_released", 16'(puc_req), 16'h0);
      rd(A_COUNT,  16'h0001, "t2_count");
      rd(A_STATUS, 16'h8004, "t2_status");

      // 3: second violation does not overwrite the first-fault log
      set_viol(1'b1, 3'b001, 16'hE100);
      tick();
      set_viol(1'b0, 3'b000, 16'h0000);
      repeat (20) tick();
      rd(A_STATUS, 16'h8004, "t3_status");
      rd(A_VPC,    16'h1234, "t3_vpc");
      rd(A_COUNT,  16'h0002, "t3_count");

      // 4: count saturation and bus clears
      for (int i = 0; i < 300; i++) begin
         set_viol(1'b1, 3'b001, 16'(i));
         tick();
         set_viol(1'b0, 3'b000, 16'h0000);
         repeat (H + 1) tick();
      end
      rd(A_COUNT, 16'h00FF, "t4_count_sat");
      wr(A_STATUS, 16'h8000, 2'b11);
      rd(A_STATUS, 16'h0000, "t4_status_w1c");
      wr(A_COUNT, 16'h1234, 2'b11);
      rd(A_COUNT, 16'h0000, "t4_count_clr");

      // 5: capture wins over a same-edge W1C
      set_viol(1'b1, 3'b001, 16'hAAAA);
      tick();
      set_viol(1'b0, 3'b000, 16'h0000);
      repeat (H + 2) tick();
      rd(A_STATUS, 16'h8001, "t5_status_pre");
      set_viol(1'b1, 3'b000, 16'hBEEF);
      wr(A_STATUS, 16'h8000, 2'b11);
      set_viol(1'b0, 3'b000, 16'h0000);
      rd(A_STATUS, 16'h8008, "t5_status_other");
      rd(A_VPC,    16'hBEEF, "t5_vpc");
      rd(A_COUNT,  16'h0002, "t5_count");
      repeat (H + 2) tick();

      // 6: asynchronous reset in the middle of HOLD
      set_viol(1'b1, 3'b010, 16'h5555);
      tick();
      set_viol(1'b0, 3'b000, 16'h0000);
      repeat (4) tick();
      check("t6_puc_before", 16'(puc_req), 16'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_puc_async", 16'(puc_req), 16'h0);
      check("t6_active_async", 16'(viol_active), 16'h0);
      tick();
      reset_n = 1'b1;
      tick();
      rd(A_STATUS, 16'h0000, "t6_status");
      rd(A_VPC,    16'h0000, "t6_vpc");
      rd(A_COUNT,  16'h0000, "t6_count");

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         set_viol(($urandom_range(0, 9) == 0) || ($urandom_range(0, 7) == 0 && hw_reset),
                  3'($urandom_range(0, 7)), 16'($urandom));
         bus.per_en   = ($urandom_range(0, 1) == 1);
         bus.per_addr = 14'(A_STATUS - 14'd1 + 14'($urandom_range(0, 4)));
         bus.per_we   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         bus.per_din  = 16'($urandom) | (($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000);
         if ($urandom_range(0, 499) == 0) begin
            #2;
            reset_n = 1'b0;
            #1;
            reset_n = 1'b1;
         end
         tick();
      end
      set_viol(1'b0, 3'b000, 16'h0000);
      bus_idle();
      repeat (H + 4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
